// File: rtl/mult8_seq.sv
// Sequential 8x8 unsigned shift-add multiplier with a start/done handshake.
// The adder8b and mux8b datapath primitives are defined here so the block is self-contained.

module adder8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
endmodule

module mux8b (
  input  logic       sel,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  output logic [7:0] y
);
  assign y = sel ? d1 : d0;
endmodule

module mult8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] m;
  logic [7:0] p;
  logic [7:0] q;
  logic [3:0] cnt;
  logic [7:0] addend;
  logic [7:0] sum;
  logic       carry;
  logic [7:0] q_next;
  logic       load;

  assign load = start && ((state == IDLE) || (state == DONE));

  mux8b u_addend_mux (
    .sel (q[0]),
    .d0  (8'h00),
    .d1  (m),
    .y   (addend)
  );

  adder8b u_adder (
    .a    (p),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  // Q either takes the new multiplier on a load or shifts in the adder's low sum bit.
  mux8b u_q_mux (
    .sel (load),
    .d0  ({sum[0], q[7:1]}),
    .d1  (b),
    .y   (q_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = (cnt == 4'd7) ? DONE : RUN;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The carry-out lands in P's MSB, so the full 16-bit product never overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      m   <= 8'h00;
      p   <= 8'h00;
      q   <= 8'h00;
      cnt <= 4'd0;
    end else if (load) begin
      m   <= a;
      p   <= 8'h00;
      q   <= q_next;
      cnt <= 4'd0;
    end else if (state == RUN) begin
      p   <= {carry, sum[7:1]};
      q   <= q_next;
      cnt <= cnt + 4'd1;
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign product = {p, q};

endmodule

// File: tb/tb_mult8_seq.sv
// Bench for mult8_seq: directed vector table, handshake corner sequences and
// random operands checked against a plain-arithmetic product model.

module tb_mult8_seq;
  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int vectors;
  int miscompares;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs[5];

  mult8_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] refProduct(input logic [7:0] x, input logic [7:0] y);
    int full;
    full = int'(x) * int'(y);
    return full[15:0];
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present a request for one clock; the accepting edge follows this negedge.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
  endtask

  // Walk the 8 RUN cycles and land on the DONE cycle, checking timing and result.
  task automatic runAndCheck(input logic [15:0] expected, input string name, input bit hold);
    int busyCycles;
    int doneInRun;
    busyCycles = 0;
    doneInRun  = 0;
    @(negedge clk);
    start = hold;
    if (hold) begin
      a = 8'h03;
      b = 8'h05;
    end
    for (int i = 0; i < 8; i++) begin
      if (busy) busyCycles++;
      if (done) doneInRun++;
      if (hold && i == 7) start = 1'b0;
      @(negedge clk);
    end
    checkOutput({name, "_busy_cycles"}, busyCycles, 8);
    checkOutput({name, "_done_in_run"}, doneInRun, 0);
    checkOutput({name, "_done"}, int'(done), 1);
    checkOutput({name, "_busy_in_done"}, int'(busy), 0);
    checkOutput({name, "_product"}, int'(product), int'(expected));
  endtask

  task automatic checkIdle(input logic [15:0] expected, input string name);
    @(negedge clk);
    checkOutput({name, "_idle_done"}, int'(done), 0);
    checkOutput({name, "_idle_busy"}, int'(busy), 0);
    checkOutput({name, "_idle_product"}, int'(product), int'(expected));
  endtask

  task automatic countDone(input int cycles, input int expected, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checkOutput(name, seen, expected);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;

    vecs[0] = '{8'h0F, 8'h11, 16'h00FF};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'hAB, 16'h0000};
    vecs[3] = '{8'hAB, 8'h01, 16'h00AB};
    vecs[4] = '{8'h07, 8'h09, 16'h003F};

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_product", int'(product), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b);
      runAndCheck(vecs[i].prod, $sformatf("vec%0d", i), 1'b0);
      checkIdle(vecs[i].prod, $sformatf("vec%0d", i));
    end

    // Start held high and operands changed mid-run must not disturb the result.
    applyStimulus(8'h0F, 8'h11);
    runAndCheck(16'h00FF, "hold", 1'b1);
    checkIdle(16'h00FF, "hold");
    countDone(12, 0, "hold_single_done");

    // Back-to-back: a new request during the DONE cycle starts the next op immediately.
    applyStimulus(8'h0F, 8'h11);
    runAndCheck(16'h00FF, "b2b_first", 1'b0);
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    runAndCheck(16'h03A8, "b2b_second", 1'b0);
    checkIdle(16'h03A8, "b2b_second");

    // Reset on the 4th RUN cycle abandons the operation with no done pulse.
    applyStimulus(8'hAB, 8'hCD);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    checkOutput("midrst_product", int'(product), 0);
    countDone(12, 0, "midrst_no_done");
    applyStimulus(8'h07, 8'h09);
    runAndCheck(16'h003F, "midrst_after", 1'b0);
    checkIdle(16'h003F, "midrst_after");

    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      applyStimulus(ra, rb);
      runAndCheck(refProduct(ra, rb), $sformatf("rand%0d", i), 1'b0);
      checkIdle(refProduct(ra, rb), $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
